muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request strobe, sampled only while busy=0.
REQ-005 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 A  input  32  operand 1: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 B  input  32  operand 2: multiplier or divisor; ignored for MTHI/MTLO.
REQ-008 busy  output  1  high while a multiply or divide is in progress.
REQ-009 done  output  1  one-cycle pulse when a multiply or divide result is valid on hi/lo.
REQ-010 hi  output  32  HI register: product[63:32] or remainder.
REQ-011 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and FIX.
- IDLE->CALC on start=1 with op in {000..011}.
- CALC->FIX after exactly 32 iterations.
- FIX->IDLE unconditionally.
REQ-013 Operands SHALL be captured at the accepting edge; later changes to A/B/op SHALL NOT affect the running operation.
REQ-014 Iterations SHALL work on 32-bit magnitudes.
- Signed ops (000, 010) take absolute values.
- Unsigned ops use the raw operands.
- One result bit per CALC cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-015 FIX SHALL apply sign correction and write hi/lo plus done=1, visible on the cycle after FIX.
- Product is negated if the operand signs differ.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-016 Timing for start accepted at edge k:
- busy=1 in cycles k+1..k+33.
- done=1 and busy=0 in cycle k+34.
- hi/lo are updated in cycle k+34.
REQ-017 busy SHALL be registered; done SHALL be high for exactly one cycle per completed multiply or divide.
REQ-018 hi/lo SHALL hold their previous values while busy=1 and SHALL change only at FIX completion, MTHI/MTLO, or reset.
REQ-019 MTHI/MTLO with start=1 and busy=0 SHALL write A into hi/lo at that edge.
- visible next cycle
- busy and done stay 0
- the other register is unchanged
REQ-020 start=1 while busy=1 SHALL be ignored for every op, including MTHI/MTLO; no queuing.
REQ-021 start=1 with op 110/111 SHALL be ignored: no state change.
REQ-022 A new start MAY be accepted in the same cycle done=1, since busy=0; the next op then starts with zero idle cycles.
REQ-023 Divide by zero (B=0), DIV and DIVU, SHALL complete with normal timing.
- LO=32'hFFFFFFFF
- HI=A, unmodified dividend
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-025 MULT of 32'h80000000 by 32'h80000000 SHALL give {HI,LO}=64'h4000000000000000; absolute values use 33-bit-safe magnitude.

Reset
REQ-026 rst=1 at an edge SHALL force:
- state=IDLE
- busy=0, done=0
- hi=32'h0, lo=32'h0
- internal counters and accumulators cleared
REQ-027 rst SHALL take priority over start, including mid-CALC and in FIX; the aborted operation SHALL produce no done pulse and no hi/lo update.
REQ-028 After rst is released, start SHALL be accepted on the first edge with rst=0.

Verification
REQ-029 MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF -> done at k+34, HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-030 MULT A=-7 (32'hFFFFFFF9), B=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-031 DIV A=-7, B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU A=100, B=0 -> LO=32'hFFFFFFFF, HI=100.
REQ-032 MTHI A=32'h12345678, then MULTU start at k+5 during busy -> second start ignored, done only once, hi/lo as for the first op.
REQ-033 DIVU started, rst=1 at k+10 -> busy=0, done=0, hi=lo=0 at k+11; no done pulse at k+34.
REQ-034 Back-to-back: start asserted in the done cycle of op 1 -> op 2 done exactly 34 cycles later; hi/lo hold op-1 results until then.

Source files
------------

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit signed/unsigned multiply and divide unit with HI/LO registers.
// One result bit per CALC cycle; FIX applies sign correction and writes hi/lo.
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_next;
    logic [4:0]  cnt;
    logic [63:0] p, p_calc, prod;
    logic [31:0] m, a_r, a_mag, b_mag, quot, rem;
    logic [32:0] mul_sum, r_sh, diff;
    logic        is_div, neg_res, neg_rem, div_zero, sgn, go;

    assign sgn   = ~op[0];
    assign go    = start && !op[2];
    assign a_mag = (sgn && A[31]) ? -A : A;
    assign b_mag = (sgn && B[31]) ? -B : B;
    // p holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign mul_sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
    assign r_sh    = {p[63:32], p[31]};
    assign diff    = r_sh - {1'b0, m};
    assign p_calc  = !is_div ? {mul_sum, p[31:1]}
                   : diff[32] ? {r_sh[31:0], p[30:0], 1'b0} : {diff[31:0], p[30:0], 1'b1};
    assign prod = neg_res ? -p : p;
    assign quot = neg_res ? -p[31:0] : p[31:0];
    assign rem  = neg_rem ? -p[63:32] : p[63:32];

    always_comb begin
        state_next = state;
        state_next = (state == IDLE && go) ? CALC
                   : (state == CALC && cnt == 5'd31) ? FIX
                   : (state == FIX) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            p        <= '0;
            m        <= '0;
            a_r      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= state_next != IDLE;
            done  <= state == FIX;
            if (state == IDLE && start) begin
                if (op == 3'b100) hi <= A;
                if (op == 3'b101) lo <= A;
                if (go) begin
                    cnt      <= '0;
                    p        <= {32'd0, op[1] ? a_mag : b_mag};
                    m        <= op[1] ? b_mag : a_mag;
                    a_r      <= A;
                    is_div   <= op[1];
                    neg_res  <= sgn && (A[31] ^ B[31]);
                    neg_rem  <= sgn && A[31];
                    div_zero <= op[1] && B == 32'd0;
                end
            end
            if (state == CALC) begin
                p   <= p_calc;
                cnt <= cnt + 5'd1;
            end
            if (state == FIX) begin
                hi <= div_zero ? a_r : is_div ? rem : prod[63:32];
                lo <= div_zero ? 32'hFFFF_FFFF : is_div ? quot : prod[31:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: vector table, randomized model comparison and multi-cycle corner sequences for muldiv.
module tb_muldiv;
    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic [2:0]  op;
    logic [31:0] A, B, hi, lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    muldiv dut (.clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
                .busy(busy), .done(done), .hi(hi), .lo(lo));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint q, r;
        longint unsigned uq, ur;
        if (o == 3'd0) return sa * sb;
        if (o == 3'd1) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // starts an op in the current cycle, checks busy/hold through k+33 and the result at k+34
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
        logic ok;
        ok = 1'b1;
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(0, 3));
        for (int i = 1; i <= 33; i++) begin
            if (!(busy === 1'b1 && done === 1'b0 && hi === m_hi && lo === m_lo)) ok = 1'b0;
            tick();
        end
        check({name, " busy/hold"}, ok, 1);
        check({name, " done"}, {busy, done}, 2'b01);
        check({name, " hilo"}, {hi, lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        vec_t vecs[10];
        logic [2:0] ro;
        logic [31:0] ra, rb;
        int dones;
        logic [63:0] seen;
        vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{3'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9] = '{3'd0, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};

        rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        tick(); tick();
        check("reset", {busy, done, hi, lo}, '0);
        rst = 1'b0;

        start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        tick();
        start = 1'b0;
        check("mthi", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'h0});
        start = 1'b1; op = 3'd5; A = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        check("mtlo", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'hCAFE_F00D});
        m_hi = 32'h1234_5678; m_lo = 32'hCAFE_F00D;
        start = 1'b1; op = 3'd6; A = 32'hDEAD_BEEF; B = 32'd3;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        check("noop", {busy, done, hi, lo}, {2'b00, m_hi, m_lo});

        // consecutive do_op calls start in the done cycle: back-to-back issue
        for (int i = 0; i < 10; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));
        tick();
        check("single done", done, 0);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d op%0d", i, ro));
        end

        // starts while busy are dropped
        start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'd1; A = 32'd9; B = 32'd9;
        tick();
        op = 3'd4; A = 32'hAAAA_5555;
        tick();
        start = 1'b0;
        dones = 0; seen = '0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                dones++;
                seen = {hi, lo};
            end
            tick();
        end
        check("busy start done count", dones, 1);
        check("busy start result", seen, 64'd15);
        m_hi = 32'd0; m_lo = 32'd15;

        // reset mid-CALC
        start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst calc", {busy, done, hi, lo}, '0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) dones++;
            tick();
        end
        check("rst calc no done", dones, 0);
        m_hi = '0; m_lo = '0;

        // start accepted on the first edge after reset release
        do_op(3'd1, 32'd6, 32'd7, 64'd42, "post rst");

        // reset during FIX
        start = 1'b1; op = 3'd0; A = 32'd11; B = 32'd13;
        tick();
        start = 1'b0;
        repeat (32) tick();
        check("in fix", {busy, done}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst fix", {busy, done, hi, lo}, '0);
        tick();
        check("rst fix no done", {busy, done, hi, lo}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
